// File: rtl/mpc_sram_req_ctrl.sv
// mpc_sram_req_ctrl
// Request/response front-end for the single-port 1RW SRAM wrapper (mpc_sram).
// A valid/ready request stream is turned into SRAM accesses. Read data, which
// arrives one cycle after the read strobe, is captured into a small response
// FIFO, so consumer backpressure never loses a word. A request is only accepted
// while the FIFO has a free slot for every read still in the pipe. This credit
// check covers writes too, which keeps ordering trivial.
// Optional feature macro: MPC_SRAM_REQ_CTRL_PARITY_EN
//   When defined, an even-parity bit is appended as the SRAM word MSB on writes.
//   It is checked on read capture and reported on rsp_err alongside the data.
//   When undefined, the SRAM word is DATA_SIZE wide and rsp_err is tied to 0.
module mpc_sram_req_ctrl #(
   parameter  int ADDR_SIZE = 8,
   parameter  int DATA_SIZE = 32,
   parameter  int RSP_DEPTH = 4,
   localparam int SRAM_W    = DATA_SIZE
`ifdef MPC_SRAM_REQ_CTRL_PARITY_EN
                              + 1
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [DATA_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_SIZE-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 sram_cs,
   output logic                 sram_we,
   output logic [ADDR_SIZE-1:0] sram_addr,
   output logic [SRAM_W-1:0]    sram_wdata,
   input  logic [SRAM_W-1:0]    sram_rdata
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RSP_DEPTH);
   localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             inflight_q, inflight_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W:0]   creditsUsed;
   logic             readIssue;
   logic             push;
   logic             pop;

   logic [DATA_SIZE-1:0] dataMem [RSP_DEPTH];

   // Pointers wrap with an explicit compare so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check: occupied slots plus the read whose data lands next cycle.
   // Only registered state feeds req_ready, so it never depends on req_valid.
   assign creditsUsed = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign req_ready   = (creditsUsed < DEPTH_EXT);

   // The issue path is a pure pass-through in the accept cycle. we is masked
   // when the SRAM is not selected, so the SRAM never sees a stray write strobe.
   assign sram_cs   = req_valid && req_ready;
   assign sram_we   = sram_cs && req_we;
   assign sram_addr = req_addr;
   assign readIssue = sram_cs && !req_we;

`ifdef MPC_SRAM_REQ_CTRL_PARITY_EN
   assign sram_wdata = {^req_wdata, req_wdata};
`else
   assign sram_wdata = req_wdata;
`endif

   // A read issued last cycle has its SRAM data on sram_rdata now, so the data
   // is captured unconditionally. Credits guarantee that a slot is free.
   assign push      = inflight_q;
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_rdata = dataMem[rdPtr_q];

   // Next-state for occupancy, the in-flight flag and the FIFO pointers.
   always_comb begin
      count_d    = count_q;
      inflight_d = readIssue;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      if (push) begin
         wrPtr_d = nextPtr(wrPtr_q);
      end
      if (pop) begin
         rdPtr_d = nextPtr(rdPtr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register. Reset drops any in-flight read and flushes the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         inflight_q <= 1'b0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
      end
   end

   // Response data storage. It has no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         dataMem[wrPtr_q] <= sram_rdata[DATA_SIZE-1:0];
      end
   end

`ifdef MPC_SRAM_REQ_CTRL_PARITY_EN
   logic errMem [RSP_DEPTH];

   // Parity over the full SRAM word, so any single-bit flip reads back as odd.
   // It is stored with the data so that rsp_err stays aligned to its response.
   always_ff @(posedge clk) begin
      if (push) begin
         errMem[wrPtr_q] <= ^sram_rdata;
      end
   end

   assign rsp_err = errMem[rdPtr_q];
`else
   assign rsp_err = 1'b0;
`endif

`ifndef SYNTHESIS
   // The credit scheme must make FIFO overflow and underflow unreachable.
   noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count_q != COUNT_FULL));
   noUnderflow: assert property (@(posedge clk) disable iff (!rst_n)
      pop |-> (count_q != '0));
`endif

endmodule
